// File: rtl/ctrl_hazard_tracker_if.sv
// ---------------------------------------------------------------------------
// ctrl_hazard_tracker_if
//
// Purpose:
//    Groups the signals between the decode/execute control path and the
//    pipeline hazard tracker into one bundle.
//
// Signal summary:
//    RegWriteD, ResultSrcD    decode-stage control bits (writes rd / is a load)
//    Rs1D, Rs2D, RdD          decode-stage register specifiers
//    PCSrcE                   execute-stage taken branch / redirect
//    ForwardAE, ForwardBE     ALU operand selects (00 RF, 10 M, 01 W)
//    StallF, StallD           hold PC / IF-ID register
//    FlushD, FlushE           bubble IF-ID / ID-EX register
//    stall_cnt, flush_cnt     saturating event counters
//
// Modports:
//    master   the core side, drives decode/execute info, consumes controls
//    slave    the tracker side
// ---------------------------------------------------------------------------
interface ctrl_hazard_tracker_if #(
   parameter int CNT_W = 16
);

   logic             RegWriteD;
   logic             ResultSrcD;
   logic [4:0]       Rs1D;
   logic [4:0]       Rs2D;
   logic [4:0]       RdD;
   logic             PCSrcE;

   logic [1:0]       ForwardAE;
   logic [1:0]       ForwardBE;
   logic             StallF;
   logic             StallD;
   logic             FlushD;
   logic             FlushE;
   logic [CNT_W-1:0] stall_cnt;
   logic [CNT_W-1:0] flush_cnt;

   modport master (
      output RegWriteD, ResultSrcD, Rs1D, Rs2D, RdD, PCSrcE,
      input  ForwardAE, ForwardBE, StallF, StallD, FlushD, FlushE,
      input  stall_cnt, flush_cnt
   );

   modport slave (
      input  RegWriteD, ResultSrcD, Rs1D, Rs2D, RdD, PCSrcE,
      output ForwardAE, ForwardBE, StallF, StallD, FlushD, FlushE,
      output stall_cnt, flush_cnt
   );

endinterface

// File: rtl/ctrl_hazard_tracker.sv
// ---------------------------------------------------------------------------
// ctrl_hazard_tracker
//
// Purpose:
//    Hazard unit for the five-stage RV32I core. It shadows the control
//    bundle (RegWrite, ResultSrc, register specifiers) of the instructions
//    in E, M and W. From that shadow state it produces the ALU forwarding
//    selects and the load-use stall / branch flush controls. It also keeps
//    saturating stall and flush event counters for performance debug.
//
// Ports:
//    clk    core clock, all state updates on the rising edge
//    rst    asynchronous, active-low reset
//    hz     ctrl_hazard_tracker_if.slave bundle (see the interface header)
//
// Parameters:
//    CNT_W  width of the stall/flush event counters; it must match the
//           CNT_W of the connected interface instance
// ---------------------------------------------------------------------------
module ctrl_hazard_tracker #(
   parameter int CNT_W = 16
) (
   input logic                clk,
   input logic                rst,
   ctrl_hazard_tracker_if.slave hz
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   // E-stage shadow of the instruction currently executing
   logic             RegWriteE_q, RegWriteE_d;
   logic             ResultSrcE_q, ResultSrcE_d;
   logic [4:0]       RdE_q, RdE_d;
   logic [4:0]       Rs1E_q, Rs1E_d;
   logic [4:0]       Rs2E_q, Rs2E_d;

   // M- and W-stage shadows, only what forwarding needs
   logic             RegWriteM_q, RegWriteM_d;
   logic [4:0]       RdM_q, RdM_d;
   logic             RegWriteW_q, RegWriteW_d;
   logic [4:0]       RdW_q, RdW_d;

   // Performance counters
   logic [CNT_W-1:0] stallCnt_q, stallCnt_d;
   logic [CNT_W-1:0] flushCnt_q, flushCnt_d;

   logic             redirect;
   logic             loadInE;
   logic             lwStall;
   logic             flushE;
   logic [1:0]       forwardA;
   logic [1:0]       forwardB;

   // Hazard detection. The redirect is masked by reset so that every
   // control output reads 0 while reset is held, even though PCSrcE
   // itself comes straight from the execute stage. A taken branch
   // suppresses the load-use stall: the instruction in D is squashed
   // anyway, and the PC must be free to take the target.
   always_comb begin
      redirect = hz.PCSrcE & rst;
      loadInE  = ResultSrcE_q & RegWriteE_q & (RdE_q != 5'd0);
      lwStall  = loadInE
               & ((RdE_q == hz.Rs1D) | (RdE_q == hz.Rs2D))
               & ~redirect;
      flushE   = lwStall | redirect;
   end

   // Operand A forwarding. M is the younger producer and therefore wins
   // over W. x0 never forwards because its value is hard-wired to zero.
   always_comb begin
      forwardA = 2'b00;
      if (RegWriteM_q && (RdM_q != 5'd0) && (RdM_q == Rs1E_q)) begin
         forwardA = 2'b10;
      end else if (RegWriteW_q && (RdW_q != 5'd0) && (RdW_q == Rs1E_q)) begin
         forwardA = 2'b01;
      end
   end

   // Operand B forwarding, same priority rule as operand A.
   always_comb begin
      forwardB = 2'b00;
      if (RegWriteM_q && (RdM_q != 5'd0) && (RdM_q == Rs2E_q)) begin
         forwardB = 2'b10;
      end else if (RegWriteW_q && (RdW_q != 5'd0) && (RdW_q == Rs2E_q)) begin
         forwardB = 2'b01;
      end
   end

   // E-stage next state. When the ID-EX register is flushed the E shadow
   // must hold a bubble too; otherwise a squashed instruction could still
   // trigger forwarding or a stall further down the pipe.
   always_comb begin
      RegWriteE_d  = hz.RegWriteD;
      ResultSrcE_d = hz.ResultSrcD;
      RdE_d        = hz.RdD;
      Rs1E_d       = hz.Rs1D;
      Rs2E_d       = hz.Rs2D;
      if (flushE) begin
         RegWriteE_d  = 1'b0;
         ResultSrcE_d = 1'b0;
         RdE_d        = 5'd0;
         Rs1E_d       = 5'd0;
         Rs2E_d       = 5'd0;
      end
   end

   // M and W always advance. Stalls only ever hold F and D, so anything
   // already past E keeps moving every cycle.
   always_comb begin
      RegWriteM_d = RegWriteE_q;
      RdM_d       = RdE_q;
      RegWriteW_d = RegWriteM_q;
      RdW_d       = RdM_q;
   end

   // Saturating event counters. They stick at all-ones instead of wrapping
   // so that a long debug run never reports a deceptively small count.
   always_comb begin
      stallCnt_d = stallCnt_q;
      flushCnt_d = flushCnt_q;
      if (lwStall && (stallCnt_q != CNT_MAX)) begin
         stallCnt_d = stallCnt_q + CNT_ONE;
      end
      if (redirect && (flushCnt_q != CNT_MAX)) begin
         flushCnt_d = flushCnt_q + CNT_ONE;
      end
   end

   // Shadow and counter registers. Reset wipes all in-flight tracking at
   // once, so nothing issued before reset can ever be forwarded after it.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         RegWriteE_q  <= 1'b0;
         ResultSrcE_q <= 1'b0;
         RdE_q        <= 5'd0;
         Rs1E_q       <= 5'd0;
         Rs2E_q       <= 5'd0;
         RegWriteM_q  <= 1'b0;
         RdM_q        <= 5'd0;
         RegWriteW_q  <= 1'b0;
         RdW_q        <= 5'd0;
         stallCnt_q   <= '0;
         flushCnt_q   <= '0;
      end else begin
         RegWriteE_q  <= RegWriteE_d;
         ResultSrcE_q <= ResultSrcE_d;
         RdE_q        <= RdE_d;
         Rs1E_q       <= Rs1E_d;
         Rs2E_q       <= Rs2E_d;
         RegWriteM_q  <= RegWriteM_d;
         RdM_q        <= RdM_d;
         RegWriteW_q  <= RegWriteW_d;
         RdW_q        <= RdW_d;
         stallCnt_q   <= stallCnt_d;
         flushCnt_q   <= flushCnt_d;
      end
   end

   // Output drive. All controls respond in the same cycle as the inputs.
   always_comb begin
      hz.ForwardAE = forwardA;
      hz.ForwardBE = forwardB;
      hz.StallF    = lwStall;
      hz.StallD    = lwStall;
      hz.FlushD    = redirect;
      hz.FlushE    = flushE;
      hz.stall_cnt = stallCnt_q;
      hz.flush_cnt = flushCnt_q;
   end

endmodule

// File: tb/tb_ctrl_hazard_tracker.sv
// ---------------------------------------------------------------------------
// tb_ctrl_hazard_tracker
//
// Purpose:
//    Self-checking bench for ctrl_hazard_tracker. It keeps a history queue of
//    the instructions that entered E (newest first). Expected controls are
//    derived from that history: the nearest older writer of a source
//    register supplies the forward, and a load in E feeding D stalls unless
//    a redirect is present. Directed scenarios are followed by a randomized
//    run against the same model.
// ---------------------------------------------------------------------------
module tb_ctrl_hazard_tracker;

   localparam int CNT_W   = 4;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   typedef struct {
      bit wr;
      bit ld;
      int rd;
      int rs1;
      int rs2;
   } instr_t;

   logic clk = 1'b0;
   logic rst = 1'b0;

   int errors = 0;
   int checks = 0;

   // Reference model state
   instr_t hist[$];
   int     mStall = 0;
   int     mFlush = 0;
   instr_t dIn;
   bit     dPc;
   bit     expLw;

   // Values observed at the last checkOutput
   logic [1:0]       obsFA, obsFB;
   logic             obsStallF, obsStallD, obsFlushD, obsFlushE;
   logic [CNT_W-1:0] obsStallCnt, obsFlushCnt;

   int stallBefore, flushBefore;

   always #5 clk = ~clk;

   ctrl_hazard_tracker_if #(.CNT_W(CNT_W)) hz ();

   ctrl_hazard_tracker #(.CNT_W(CNT_W)) dut (
      .clk (clk),
      .rst (rst),
      .hz  (hz)
   );

   // Nearest older instruction writing src wins; age 1 is M, age 2 is W.
   function automatic logic [1:0] modelFwd(input int src);
      if (src == 0) return 2'b00;
      for (int age = 1; age <= 2; age++) begin
         if (age < hist.size() && hist[age].wr && hist[age].rd == src)
            return (age == 1) ? 2'b10 : 2'b01;
      end
      return 2'b00;
   endfunction

   function automatic bit modelLw();
      if (hist.size() == 0) return 1'b0;
      return hist[0].ld && hist[0].wr && hist[0].rd != 0 &&
             (hist[0].rd == dIn.rs1 || hist[0].rd == dIn.rs2) && !dPc;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic applyStimulus(input bit wr, input bit ld, input int rd,
                                input int rs1, input int rs2, input bit pc);
      dIn.wr  = wr;
      dIn.ld  = ld;
      dIn.rd  = rd;
      dIn.rs1 = rs1;
      dIn.rs2 = rs2;
      dPc     = pc;
      hz.RegWriteD  = wr;
      hz.ResultSrcD = ld;
      hz.RdD        = 5'(rd);
      hz.Rs1D       = 5'(rs1);
      hz.Rs2D       = 5'(rs2);
      hz.PCSrcE     = pc;
   endtask

   // Computes the expected controls from the model, samples the DUT on the
   // falling edge and compares.
   task automatic checkOutput();
      logic [1:0] eA, eB;
      bit         eFD, eFE;
      if (rst) begin
         expLw = modelLw();
         eA    = (hist.size() > 0) ? modelFwd(hist[0].rs1) : 2'b00;
         eB    = (hist.size() > 0) ? modelFwd(hist[0].rs2) : 2'b00;
         eFD   = dPc;
         eFE   = expLw | dPc;
      end else begin
         expLw = 1'b0;
         eA    = 2'b00;
         eB    = 2'b00;
         eFD   = 1'b0;
         eFE   = 1'b0;
      end
      @(negedge clk);
      obsFA       = hz.ForwardAE;
      obsFB       = hz.ForwardBE;
      obsStallF   = hz.StallF;
      obsStallD   = hz.StallD;
      obsFlushD   = hz.FlushD;
      obsFlushE   = hz.FlushE;
      obsStallCnt = hz.stall_cnt;
      obsFlushCnt = hz.flush_cnt;
      check("ForwardAE", obsFA, eA);
      check("ForwardBE", obsFB, eB);
      check("StallF_StallD_FlushD_FlushE",
            {obsStallF, obsStallD, obsFlushD, obsFlushE},
            {expLw, expLw, eFD, eFE});
      check("stall_cnt", obsStallCnt, mStall);
      check("flush_cnt", obsFlushCnt, mFlush);
   endtask

   // Moves the model across one rising edge.
   task automatic advance();
      instr_t ent;
      @(posedge clk);
      if (rst) begin
         if (expLw || dPc) ent = '{0, 0, 0, 0, 0};
         else              ent = dIn;
         hist.push_front(ent);
         if (hist.size() > 3) void'(hist.pop_back());
         if (expLw && mStall < CNT_MAX) mStall++;
         if (dPc && mFlush < CNT_MAX)   mFlush++;
      end
      #1;
   endtask

   task automatic step(input bit wr, input bit ld, input int rd,
                       input int rs1, input int rs2, input bit pc);
      applyStimulus(wr, ld, rd, rs1, rs2, pc);
      checkOutput();
      advance();
   endtask

   // Drops reset between clock edges and checks the immediate clear, then
   // releases it just after the next rising edge.
   task automatic asyncReset();
      #2;
      rst = 1'b0;
      hist.delete();
      mStall = 0;
      mFlush = 0;
      #1;
      check("asyncReset_flush_cnt", hz.flush_cnt, 0);
      check("asyncReset_stall_cnt", hz.stall_cnt, 0);
      check("asyncReset_controls",
            {hz.ForwardAE, hz.ForwardBE, hz.StallF, hz.StallD, hz.FlushD, hz.FlushE}, 0);
      @(posedge clk);
      #1;
      rst = 1'b1;
   endtask

   initial begin
      instr_t nx;
      bit     pc;
      $display("[TB] ctrl_hazard_tracker bench, CNT_W=%0d", CNT_W);
      applyStimulus(0, 0, 0, 0, 0, 0);

      // Reset held with random inputs: everything must read 0.
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                       int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
                       int'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
         checkOutput();
         advance();
      end
      rst = 1'b1;
      step(0, 0, 0, 0, 0, 0);
      check("postRelease_allZero",
            {obsFA, obsFB, obsStallF, obsStallD, obsFlushD, obsFlushE, obsStallCnt, obsFlushCnt}, 0);

      // EX->EX then W forwarding
      step(1, 0, 5, 1, 2, 0);
      step(1, 0, 6, 5, 5, 0);
      step(0, 0, 0, 0, 5, 0);
      check("exFwd_A", obsFA, 2'b10);
      check("exFwd_B", obsFB, 2'b10);
      step(0, 0, 0, 0, 0, 0);
      check("wbFwd_B", obsFB, 2'b01);

      // M beats W, x0 never forwards
      step(1, 0, 7, 0, 0, 0);
      step(1, 0, 7, 0, 0, 0);
      step(0, 0, 0, 7, 0, 0);
      step(0, 0, 0, 0, 0, 0);
      check("priority_A", obsFA, 2'b10);
      step(1, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0);
      check("x0_A", obsFA, 2'b00);

      // Load-use: one-cycle stall, then W forward
      step(1, 1, 3, 1, 2, 0);
      step(1, 0, 9, 0, 3, 0);
      check("loadUse_stall", {obsStallF, obsStallD, obsFlushE}, 3'b111);
      step(1, 0, 9, 0, 3, 0);
      check("loadUse_oneCycle", {obsStallF, obsStallD, obsFlushE}, 3'b000);
      check("loadUse_stall_cnt", obsStallCnt, 1);
      step(0, 0, 0, 0, 0, 0);
      check("loadUse_fwdB", obsFB, 2'b01);

      // Redirect concurrent with load-use: redirect wins
      step(1, 1, 3, 0, 0, 0);
      step(1, 0, 4, 3, 0, 1);
      check("redirect_controls",
            {obsStallF, obsStallD, obsFlushD, obsFlushE}, 4'b0011);
      stallBefore = int'(obsStallCnt);
      flushBefore = int'(obsFlushCnt);
      step(0, 0, 0, 0, 0, 0);
      check("redirect_flush_cnt", obsFlushCnt, flushBefore + 1);
      check("redirect_stall_cnt", obsStallCnt, stallBefore);

      // Flush counter saturation, then asynchronous clear
      for (int i = 0; i < 20; i++) step(0, 0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 0, 0);
      check("flush_cnt_saturated", obsFlushCnt, CNT_MAX);
      applyStimulus(1, 1, 3, 3, 3, 1);
      asyncReset();

      // Randomized run; D is held while the model says the pipe is stalled.
      for (int i = 0; i < 400; i++) begin
         if (expLw) begin
            nx = dIn;
         end else begin
            nx.wr  = 1'($urandom_range(0, 1));
            nx.ld  = ($urandom_range(0, 2) == 0);
            nx.rd  = int'($urandom_range(0, 3));
            nx.rs1 = int'($urandom_range(0, 3));
            nx.rs2 = int'($urandom_range(0, 3));
         end
         pc = ($urandom_range(0, 7) == 0);
         step(nx.wr, nx.ld, nx.rd, nx.rs1, nx.rs2, pc);
         if (i == 200) begin
            applyStimulus(nx.wr, nx.ld, nx.rd, nx.rs1, nx.rs2, pc);
            asyncReset();
            expLw = 1'b0;
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
